// File: rtl/adder_ds_pipe_pkg.sv
// ---------------------------------------------------------------------------
// adder_ds_pkg
// Shared definitions for the adder_ds_pipe ALU slice:
//   op_e            - 3-bit operation codes
//   is_arith()      - op uses the shared adder (ADD, SUB, ACC)
//   is_acc()        - op touches the accumulator (ACC, ACC_LD)
//   sat_pos_bound() - largest signed value for an n-bit word (n <= 64)
//   sat_neg_bound() - smallest signed value for an n-bit word (n <= 64)
// ---------------------------------------------------------------------------
package adder_ds_pkg;

    typedef enum logic [2:0] {
        OP_PASS1  = 3'd0,
        OP_ADD    = 3'd1,
        OP_PASS2  = 3'd2,
        OP_SUB    = 3'd3,
        OP_ACC    = 3'd4,
        OP_ACC_LD = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ACC);
    endfunction

    function automatic logic is_acc(input op_e op);
        return (op == OP_ACC) || (op == OP_ACC_LD);
    endfunction

    // Bounds are produced 64 bits wide; callers size-cast to their width.
    function automatic logic [63:0] sat_pos_bound(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_bound(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/adder_ds_pipe_addsub_sat_unit.sv
// ---------------------------------------------------------------------------
// addsub_sat_unit
// Combinational N-bit add/subtract with signed-overflow detection and
// optional saturation.
//   a, b    in  N  operands
//   sub     in  1  1 = a - b, 0 = a + b
//   sat_en  in  1  clamp to signed range on overflow
//   sum     out N  result (wrapped or clamped)
//   ovf     out 1  signed overflow of the unclamped operation
// ---------------------------------------------------------------------------
module addsub_sat_unit
    import adder_ds_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         sat_en,
    output logic [N-1:0] sum,
    output logic         ovf
);

    localparam logic [N-1:0] SAT_MAX = N'(sat_pos_bound(N));
    localparam logic [N-1:0] SAT_MIN = N'(sat_neg_bound(N));

    logic [N-1:0] b_eff;
    logic [N-1:0] raw;

    // Subtraction as a + ~b + 1 so one carry chain serves both ops.
    assign b_eff = sub ? ~b : b;
    assign raw   = a + b_eff + {{(N-1){1'b0}}, sub};

    // Overflow: operands share a sign that the result does not.
    assign ovf = (a[N-1] == b_eff[N-1]) && (raw[N-1] != a[N-1]);

    // On overflow the true result has the sign of a.
    always_comb begin
        sum = raw;
        if (ovf && sat_en) begin
            sum = a[N-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/adder_ds_pipe.sv
// ---------------------------------------------------------------------------
// adder_ds_pipe
// Two-stage valid/ready ALU slice: PASS1, ADD, PASS2, SUB, ACC, ACC_LD with
// optional signed saturation. Adder operand registers load only for
// arithmetic ops so the shared adder inputs stay quiet otherwise.
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   in_valid   in  1  upstream transaction valid
//   in_ready   out 1  slice can accept a transaction this cycle
//   data_1     in  N  operand A
//   data_2     in  N  operand B
//   op         in  3  operation code (adder_ds_pkg::op_e)
//   sat_en     in  1  saturate signed result on overflow
//   out_valid  out 1  result valid
//   out_ready  in  1  downstream accepts result
//   result     out N  registered result
//   overflow   out 1  signed overflow for this result (pre-saturation)
// ---------------------------------------------------------------------------
module adder_ds_pipe
    import adder_ds_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data_1,
    input  logic [N-1:0] data_2,
    input  logic [2:0]   op,
    input  logic         sat_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow
);

    // Stage 1 state
    logic         s1_valid_q;
    op_e          s1_op_q;
    logic         s1_sat_q;
    logic [N-1:0] s1_pass_q;
    logic [N-1:0] add_a_q;
    logic [N-1:0] add_b_q;

    // Stage 2 state
    logic         s2_valid_q;
    logic [N-1:0] result_q;
    logic         ovf_q;

    logic         s1_adv;
    logic         in_fire;
    op_e          op_dec;
    logic [N-1:0] acc_val;
    logic [N-1:0] adder_b;
    logic [N-1:0] adder_sum;
    logic         adder_ovf;
    logic [N-1:0] result_d;
    logic         ovf_d;

    assign s1_adv    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

    // Reserved codes, and accumulator codes when no accumulator is built,
    // are folded into PASS1 at capture so stage 2 never sees them.
    always_comb begin
        op_dec = op_e'(op);
        if ((op_dec == OP_RSV6) || (op_dec == OP_RSV7) ||
            (!ACC_EN && is_acc(op_dec))) begin
            op_dec = OP_PASS1;
        end
    end

    // Stage 1: capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_PASS1;
            s1_sat_q   <= 1'b0;
            s1_pass_q  <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= op_dec;
            s1_sat_q   <= sat_en;
            s1_pass_q  <= (op_dec == OP_PASS2) ? data_2 : data_1;
            if (is_arith(op_dec)) begin
                add_a_q <= data_1;
                add_b_q <= data_2;
            end
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Accumulator: written on the same edge that moves an ACC/ACC_LD into
    // stage 2, so a following ACC in stage 1 already sees the new value.
    generate
        if (ACC_EN) begin : gen_acc
            logic [N-1:0] acc_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (s1_adv) begin
                    if (s1_op_q == OP_ACC) begin
                        acc_q <= adder_sum;
                    end else if (s1_op_q == OP_ACC_LD) begin
                        acc_q <= s1_pass_q;
                    end
                end
            end

            assign acc_val = acc_q;
        end else begin : gen_no_acc
            assign acc_val = '0;
        end
    endgenerate

    assign adder_b = (s1_op_q == OP_ACC) ? acc_val : add_b_q;

    addsub_sat_unit #(
        .N (N)
    ) u_addsub (
        .a      (add_a_q),
        .b      (adder_b),
        .sub    (s1_op_q == OP_SUB),
        .sat_en (s1_sat_q),
        .sum    (adder_sum),
        .ovf    (adder_ovf)
    );

    always_comb begin
        result_d = s1_pass_q;
        ovf_d    = 1'b0;
        if (is_arith(s1_op_q)) begin
            result_d = adder_sum;
            ovf_d    = adder_ovf;
        end
    end

    // Stage 2: result register; holds while stalled or empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= 1'b1;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_ds_pipe.sv
module tb_adder_ds_pipe;

    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_1 = '0;
    logic [7:0] data_2 = '0;
    logic [2:0] op = '0;
    logic       sat_en = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       overflow;

    always #5 clk = ~clk;

    adder_ds_pipe #(
        .N      (N),
        .ACC_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_1    (data_1),
        .data_2    (data_2),
        .op        (op),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [7:0] r;
        logic       o;
    } exp_t;

    exp_t       sb_q[$];
    int         fire_cyc[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_acc = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_r = '0;
    logic       prev_o = 1'b0;
    bit         saw_block = 1'b0;
    bit         rnd_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: signed integer arithmetic on the op definitions.
    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic s, output logic [7:0] r, output logic ov);
        int sa;
        int sb;
        int sacc;
        int full;
        bit arith;
        sa    = $signed(a);
        sb    = $signed(b);
        sacc  = $signed(m_acc);
        arith = 1'b0;
        full  = 0;
        r     = a;
        ov    = 1'b0;
        case (o)
            3'd1: begin full = sa + sb;   arith = 1'b1; end
            3'd2: r = b;
            3'd3: begin full = sa - sb;   arith = 1'b1; end
            3'd4: begin full = sacc + sa; arith = 1'b1; end
            3'd5: begin r = a; m_acc = a; end
            default: r = a;
        endcase
        if (arith) begin
            ov = (full > 127) || (full < -128);
            if (ov && s) r = (full > 0) ? 8'h7F : 8'h80;
            else         r = 8'(full);
            if (o == 3'd4) m_acc = r;
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: the output fire happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("hold_result", result, prev_r);
                chk("hold_overflow", overflow, prev_o);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output actual=%0h expected=none", result);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.r);
                    chk("overflow", overflow, e.o);
                end
                fire_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = result;
            prev_o     = overflow;
        end
    end

    // Drives one transaction; returns at posedge+1 after it is accepted.
    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic s);
        exp_t e;
        bit   got;
        op = o; data_1 = a; data_2 = b; sat_en = s; in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            saw_block = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept");
            in_valid = 1'b0;
            return;
        end
        model(o, a, b, s, e.r, e.o);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_acc", dut.acc_val, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 1: ADD then PASS2, consecutive results
        fire_cyc.delete();
        send(3'd1, 8'h10, 8'h22, 1'b0);
        send(3'd2, 8'h00, 8'h5A, 1'b0);
        drain();
        if (fire_cyc.size() == 2) chk("t1_consecutive", fire_cyc[1] - fire_cyc[0], 1);
        else chk("t1_count", fire_cyc.size(), 2);

        // 2: overflow / saturation
        send(3'd1, 8'h70, 8'h20, 1'b0);
        send(3'd1, 8'h70, 8'h20, 1'b1);
        send(3'd3, 8'h80, 8'h01, 1'b1);
        drain();

        // 3: accumulator back-to-back, ADD leaves acc alone
        fire_cyc.delete();
        send(3'd5, 8'd5, 8'hEE, 1'b0);
        send(3'd4, 8'd3, 8'h11, 1'b0);
        send(3'd4, 8'd4, 8'h22, 1'b0);
        send(3'd1, 8'd1, 8'd1, 1'b0);
        send(3'd4, 8'd1, 8'h33, 1'b0);
        drain();
        if (fire_cyc.size() == 5) begin
            chk("t3_consec_a", fire_cyc[1] - fire_cyc[0], 1);
            chk("t3_consec_b", fire_cyc[2] - fire_cyc[1], 1);
        end else chk("t3_count", fire_cyc.size(), 5);
        chk("t3_acc", dut.acc_val, 8'd13);

        // 4: stream with 3-cycle backpressure
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(3'd1, 8'($urandom), 8'($urandom), 1'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_in_ready_drop", saw_block, 1);

        // 5: operand isolation
        send(3'd1, 8'h11, 8'h22, 1'b0);
        send(3'd0, 8'h33, 8'h44, 1'b0);
        send(3'd2, 8'h55, 8'h66, 1'b0);
        drain();
        chk("t5_add_a", dut.add_a_q, 8'h11);
        chk("t5_add_b", dut.add_b_q, 8'h22);

        // 6: reset with both stages full
        send(3'd5, 8'h30, 8'h00, 1'b0);
        send(3'd4, 8'h03, 8'h00, 1'b0);
        drain();
        chk("t6_acc_before", dut.acc_val, 8'h33);
        out_ready = 1'b0;
        send(3'd1, 8'h01, 8'h02, 1'b0);
        send(3'd1, 8'h03, 8'h04, 1'b0);
        @(negedge clk);
        chk("t6_full_out_valid", out_valid, 1);
        chk("t6_full_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_result", result, 0);
        chk("t6_rst_acc", dut.acc_val, 0);
        sb_q.delete();
        m_acc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(3'd4, 8'd2, 8'h00, 1'b0);
        drain();

        // 7: randomized traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    send(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_ds_pipe.md
Name: adder_ds_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle select/add datapath register.
- Two-stage pipelined ALU slice in the datapath-sharing power-optimisation family. Supported operations: pass, add, subtract and accumulate, with optional signed saturation.
- Operand isolation on the shared adder: adder inputs toggle only for arithmetic ops.
- Sits between an upstream operand producer and a downstream consumer, using valid/ready on both sides.

Parameters:
- N, 32, datapath width in bits (N >= 2).
- ACC_EN, 1, 1 = accumulator and ACC/ACC_LD ops present; 0 = ACC/ACC_LD decode as PASS1 and no accumulator is built.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  block can accept a transaction this cycle
- data_1  in  N  operand A
- data_2  in  N  operand B
- op  in  3  operation code (see Behaviour)
- sat_en  in  1  saturate signed result on overflow
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  N  registered result
- overflow  out  1  signed overflow occurred for this result (pre-saturation)

Behaviour:
- Op codes:
  - 0 PASS1: result = data_1.
  - 1 ADD: result = data_1 + data_2.
  - 2 PASS2: result = data_2.
  - 3 SUB: result = data_1 - data_2.
  - 4 ACC: acc = acc + data_1; result = new acc.
  - 5 ACC_LD: acc = data_1; result = data_1.
  - 6, 7: reserved, behave as PASS1.
- Reset (rst_n low, asynchronous):
  - s1_valid, s2_valid, out_valid, overflow = 0.
  - result = 0; acc = 0; stage-1 operand registers = 0.
  - in_ready reads 1 in the first cycle after reset release.
- Handshake:
  - Input fires when in_valid && in_ready.
  - Output fires when out_valid && out_ready.
  - in_ready = !s1_valid || s1_adv, combinational; no combinational path from in_valid to in_ready.
  - s1_adv = s1_valid && (!s2_valid || out_ready).
  - out_valid = s2_valid.
  - result and overflow hold stable while out_valid && !out_ready.
- Stage 1 (capture):
  - On input fire, register op, sat_en and the pass operand.
  - Adder operand registers (add_a, add_b) load only when op ∈ {ADD, SUB, ACC}; otherwise they hold their previous value (operand isolation).
  - For ACC, add_b is unused; the adder takes acc as its second input.
- Stage 2 (compute/register): on s1_adv, compute and load result, overflow and s2_valid = 1.
  - If stage 2 empties without refill, s2_valid = 0; result keeps its last value.
- Latency and throughput:
  - Input fire at edge k gives out_valid high after edge k+2 when not stalled.
  - Throughput is 1 transaction/cycle with out_ready held high.
  - Backpressure stalls stage 2 first, then stage 1; no transaction is dropped or duplicated.
- Arithmetic:
  - Modulo 2^N, two's complement.
  - overflow = signed overflow of the ADD/SUB/ACC operation; always 0 for PASS1, PASS2, ACC_LD and reserved codes.
  - With sat_en = 1 and overflow, result clamps to 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow).
  - overflow is still reported as 1 when clamped.
- Accumulator:
  - Updates on the s1_adv edge that loads an ACC/ACC_LD transaction, so back-to-back ACC ops see the updated acc with no bubble.
  - acc stores the saturated value when sat_en clamps.
  - Non-ACC ops never modify acc.
- Simultaneous input fire and output fire in one cycle is legal and required for full throughput.
- Reset asserted mid-operation discards all in-flight transactions and clears acc.

Decomposition:
- Package adder_ds_pkg:
  - op_e enum with the 3-bit codes above.
  - Helpers is_arith(op) and is_acc(op).
  - Saturation bound constants as functions of N.
- One combinational sub-module, addsub_sat_unit:
  - Parameter N.
  - Inputs a, b, sub, sat_en.
  - Outputs sum and ovf.
  - Instantiated once in stage 2 (shared by ADD/SUB/ACC).

Test Plan:
1. N=8, out_ready=1: ADD 0x10+0x22, then PASS2 data_2=0x5A -> result 0x32 then 0x5A on consecutive cycles, 2 cycles after each input fire; overflow=0.
2. N=8: ADD 0x70+0x20 with sat_en=0 -> result 0x90, overflow=1. Same with sat_en=1 -> result 0x7F, overflow=1. SUB 0x80-0x01 with sat_en=1 -> result 0x80, overflow=1.
3. N=8: ACC_LD 5, then ACC 3, ACC 4 back-to-back -> results 5, 8, 12 on three consecutive cycles; an intervening ADD leaves acc unchanged.
4. Stream 6 ADD transactions, out_ready low for 3 cycles mid-stream:
   - in_ready drops once both stages are full.
   - result/overflow hold stable while stalled.
   - All 6 results arrive in order, no loss or duplicates.
5. Issue PASS1 then PASS2 after an ADD -> internal add_a/add_b remain at the ADD operands (no toggle) while the pass results are correct.
6. Assert rst_n low while both stages are valid and acc=0x33 -> out_valid=0, result=0, acc=0 immediately; in_ready=1 after release; next ACC 2 returns 2.
